// File: rtl/ram_dumper_pkg.sv
// Shared definitions for the result-RAM datapath: RAM geometry used by both
// the accumulate/write engine and the dumper, plus the dumper state encoding.
package ram_dumper_pkg;

  localparam int RAM_ADDR_W = 6;
  localparam int RAM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAIT    = 2'b01,
    PRESENT = 2'b10,
    FINISH  = 2'b11
  } dump_state_e;

endpackage : ram_dumper_pkg

// File: rtl/ram_dumper.sv
// Sequentially reads result-RAM words 0..DEPTH-1 after a start pulse and
// hands each one to a consumer over valid/ready, together with a last flag
// and a running wrapping sum. done is a level that stays high until the next
// accepted start.
module ram_dumper
  import ram_dumper_pkg::*;
#(
  parameter int ADDR_W   = RAM_ADDR_W,
  parameter int DATA_W   = RAM_DATA_W,
  parameter int DEPTH    = 33,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [DATA_W-1:0] out_sum,
  output logic              busy,
  output logic              done
);

  // The address is registered, so it needs one clock to reach the RAM before
  // the READ_LAT read pipeline starts. The wait therefore spans READ_LAT+1
  // cycles: counter runs 0..READ_LAT and the word is captured on the last one.
  localparam int                CNT_W     = $clog2(READ_LAT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(READ_LAT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [DATA_W-1:0] acc_q,   acc_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [DATA_W-1:0] sum_q,   sum_d;
  logic              valid_q, valid_d;
  logic              last_q,  last_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;

  logic [DATA_W-1:0] acc_plus_dout;

  assign acc_plus_dout = acc_q + ram_dout;

  // Next-state and output-register logic; every register holds by default.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    sum_d   = sum_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = done_q;

    case (state_q)
      IDLE, FINISH: begin
        if (start) begin
          addr_d  = '0;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          data_d  = ram_dout;
          sum_d   = acc_plus_dout;
          acc_d   = acc_plus_dout;
          last_d  = (addr_q == LAST_ADDR);
          valid_d = 1'b1;
          state_d = PRESENT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      PRESENT: begin
        // Word, last and sum stay frozen until the consumer takes the word.
        if (out_ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            // Address is left parked on the final word; no wrap past DEPTH-1.
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = FINISH;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any dump in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ram_addr  = addr_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign out_sum   = sum_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule : ram_dumper

// File: tb/tb_ram_dumper.sv
// Scoreboard bench for ram_dumper. Three instances cover the configurations:
//   0: DEPTH=33, READ_LAT=1   1: DEPTH=4, READ_LAT=3   2: DEPTH=1, READ_LAT=1
// Stimulus pushes expected words into per-instance queues; a negedge monitor
// compares whatever the DUT presents against the queue head and pops on
// handshake.
module tb_ram_dumper;
  import ram_dumper_pkg::*;

  localparam int N = 3;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [31:0] sum;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start     [N];
  logic        out_ready [N];
  logic        out_valid [N];
  logic        out_last  [N];
  logic        busy      [N];
  logic        done      [N];
  logic [5:0]  ram_addr  [N];
  logic [31:0] ram_dout  [N];
  logic [31:0] out_data  [N];
  logic [31:0] out_sum   [N];
  logic [31:0] mem       [N][64];

  exp_t exp_q [N][$];
  int   hs_cnt [N];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      localparam int DEP = (gi == 0) ? 33 : ((gi == 1) ? 4 : 1);
      localparam int RL  = (gi == 1) ? 3 : 1;
      logic [31:0] pipe [RL];

      ram_dumper #(
        .ADDR_W(RAM_ADDR_W), .DATA_W(RAM_DATA_W), .DEPTH(DEP), .READ_LAT(RL)
      ) u_dut (
        .clk(clk), .rst(rst), .start(start[gi]),
        .ram_addr(ram_addr[gi]), .ram_dout(ram_dout[gi]),
        .out_data(out_data[gi]), .out_valid(out_valid[gi]),
        .out_ready(out_ready[gi]), .out_last(out_last[gi]),
        .out_sum(out_sum[gi]), .busy(busy[gi]), .done(done[gi])
      );

      // Behavioural RAM read port with RL register stages.
      always @(posedge clk) begin
        pipe[0] <= mem[gi][ram_addr[gi]];
        for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
      end
      assign ram_dout[gi] = pipe[RL-1];
    end
  endgenerate

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: compare presented word against queue head, pop on handshake.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < N; i++) begin
      if (!rst && out_valid[i]) begin
        if (exp_q[i].size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_word[%0d]: got %h required no word", i, out_data[i]);
        end else begin
          e = exp_q[i][0];
          check($sformatf("data[%0d]", i), out_data[i], e.data);
          check($sformatf("last[%0d]", i), 32'(out_last[i]), 32'(e.last));
          check($sformatf("sum[%0d]", i), out_sum[i], e.sum);
          if (out_ready[i]) begin
            void'(exp_q[i].pop_front());
            hs_cnt[i]++;
            $display("word inst=%0d n=%0d data=%h last=%0d sum=%h",
                     i, hs_cnt[i], out_data[i], out_last[i], out_sum[i]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump(input int i, input int n);
    logic [31:0] acc;
    acc = '0;
    for (int k = 0; k < n; k++) begin
      acc = acc + mem[i][k];
      exp_q[i].push_back('{data: mem[i][k], last: (k == n - 1), sum: acc});
    end
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget, input bit rnd, output int cyc);
    cyc = 0;
    while (cyc < budget) begin
      tick();
      cyc++;
      if (done[i]) break;
      if (rnd) out_ready[i] = 1'($urandom_range(0, 1));
    end
    if (!done[i]) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout[%0d]: done=0 required 1", i);
    end
    out_ready[i] = 1'b1;
  endtask

  task automatic end_of_dump(input string tag, input int i);
    check({tag, "_done"}, 32'(done[i]), 32'd1);
    check({tag, "_busy"}, 32'(busy[i]), 32'd0);
    check({tag, "_valid"}, 32'(out_valid[i]), 32'd0);
    check({tag, "_q_empty"}, 32'(exp_q[i].size()), 32'd0);
  endtask

  initial begin
    int cyc;
    int base;

    for (int i = 0; i < N; i++) begin
      start[i] = 1'b0;
      out_ready[i] = 1'b1;
      hs_cnt[i] = 0;
      for (int k = 0; k < 64; k++) mem[i][k] = '0;
    end
    rst = 1'b1;
    repeat (3) tick();

    // Reset state.
    check("rst_addr", 32'(ram_addr[0]), 32'd0);
    check("rst_data", out_data[0], 32'd0);
    check("rst_sum", out_sum[0], 32'd0);
    check("rst_valid", 32'(out_valid[0]), 32'd0);
    check("rst_last", 32'(out_last[0]), 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_done", 32'(done[0]), 32'd0);
    rst = 1'b0;
    tick();

    // Basic dump: words 1..33, sum 561, first valid 2 cycles after start edge.
    for (int k = 0; k < 33; k++) mem[0][k] = 32'(k + 1);
    push_dump(0, 33);
    pulse_start(0);
    check("t1_busy_after_start", 32'(busy[0]), 32'd1);
    check("t1_valid_c1", 32'(out_valid[0]), 32'd0);
    tick();
    check("t1_valid_c1b", 32'(out_valid[0]), 32'd0);
    tick();
    check("t1_valid_c2", 32'(out_valid[0]), 32'd1);
    wait_done(0, 500, 1'b0, cyc);
    check("t1_cycles", 32'(cyc + 2), 32'd99);
    check("t1_final_sum", out_sum[0], 32'd561);
    end_of_dump("t1", 0);

    // Backpressure: mem[i]=3i, random ready.
    for (int k = 0; k < 33; k++) mem[0][k] = 32'(3 * k);
    push_dump(0, 33);
    pulse_start(0);
    wait_done(0, 2000, 1'b1, cyc);
    check("t2_final_sum", out_sum[0], 32'd1584);
    end_of_dump("t2", 0);

    // Latency 3, DEPTH 4, all-ones words: wrapping sum, 5-cycle spacing.
    for (int k = 0; k < 4; k++) mem[1][k] = 32'hFFFF_FFFF;
    push_dump(1, 4);
    pulse_start(1);
    wait_done(1, 200, 1'b0, cyc);
    check("t3_cycles", 32'(cyc), 32'd20);
    check("t3_final_sum", out_sum[1], 32'hFFFF_FFFC);
    end_of_dump("t3", 1);

    // Start while busy is ignored; start after done runs a second dump.
    for (int k = 0; k < 33; k++) mem[0][k] = 32'(k + 1);
    push_dump(0, 33);
    pulse_start(0);
    base = hs_cnt[0];
    for (int c = 0; c < 200 && (hs_cnt[0] - base) < 10; c++) tick();
    check("t4_reached_word10", 32'(hs_cnt[0] - base), 32'd10);
    pulse_start(0);
    check("t4_busy_after_ignored", 32'(busy[0]), 32'd1);
    wait_done(0, 500, 1'b0, cyc);
    check("t4_words_once", 32'(hs_cnt[0] - base), 32'd33);
    end_of_dump("t4a", 0);
    push_dump(0, 33);
    pulse_start(0);
    check("t4_done_cleared", 32'(done[0]), 32'd0);
    check("t4_busy_again", 32'(busy[0]), 32'd1);
    wait_done(0, 500, 1'b0, cyc);
    check("t4_cycles", 32'(cyc), 32'd99);
    end_of_dump("t4b", 0);

    // DEPTH=1: single word with last.
    mem[2][0] = 32'h1234_5678;
    push_dump(2, 1);
    pulse_start(2);
    wait_done(2, 50, 1'b0, cyc);
    check("t6_cycles", 32'(cyc), 32'd3);
    check("t6_sum", out_sum[2], 32'h1234_5678);
    end_of_dump("t6", 2);

    // Reset during PRESENT of word 5, then a fresh dump from address 0.
    push_dump(0, 33);
    pulse_start(0);
    base = hs_cnt[0];
    for (int c = 0; c < 300; c++) begin
      tick();
      if ((hs_cnt[0] - base) >= 4) begin
        out_ready[0] = 1'b0;
        break;
      end
    end
    for (int c = 0; c < 20 && !out_valid[0]; c++) tick();
    check("t5_word5_presented", out_data[0], 32'd5);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_valid", 32'(out_valid[0]), 32'd0);
    check("t5_rst_busy", 32'(busy[0]), 32'd0);
    check("t5_rst_done", 32'(done[0]), 32'd0);
    check("t5_rst_addr", 32'(ram_addr[0]), 32'd0);
    exp_q[0].delete();
    tick();
    rst = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    base = hs_cnt[0];
    push_dump(0, 33);
    pulse_start(0);
    wait_done(0, 500, 1'b0, cyc);
    check("t5_cycles", 32'(cyc), 32'd99);
    check("t5_words", 32'(hs_cnt[0] - base), 32'd33);
    end_of_dump("t5", 0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_ram_dumper
